// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen: synchronises and debounces a raw button level and emits a
// single-cycle enable strobe per accepted press, with optional auto-repeat
// while the button stays held.
module enable_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_RATE     = 8,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   input  logic repeat_en,
   output logic enable,
   output logic btn_state
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      HELD        = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] RD_MAX  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RR_MAX  = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   // Two-flop synchroniser chain; stage gi samples sync_in[gi].
   logic [1:0] sync_reg;
   logic [1:0] sync_in;
   logic       btn_s;

   assign sync_in = {sync_reg[0], btn_in};
   assign btn_s   = sync_reg[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         // Shift the raw level one stage further into the clock domain.
         always_ff @(posedge clk) begin
            if (reset) sync_reg[gi] <= 1'b0;
            else       sync_reg[gi] <= sync_in[gi];
         end
      end
   endgenerate

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] dcnt_reg, dcnt_next;
   logic [CNT_W-1:0] rcnt_reg, rcnt_next;
   logic             rep_reg, rep_next;     // 1 once the first repeat has fired
   logic             enable_reg, enable_next;
   logic             btn_state_reg, btn_state_next;
   logic [CNT_W-1:0] rep_limit;
   logic [CNT_W-1:0] rcnt_inc;

   // The first repeat waits the long delay, later ones use the shorter rate.
   assign rep_limit = rep_reg ? RR_MAX : RD_MAX;
   assign rcnt_inc  = rcnt_reg + ONE;

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         dcnt_reg      <= '0;
         rcnt_reg      <= '0;
         rep_reg       <= 1'b0;
         enable_reg    <= 1'b0;
         btn_state_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         dcnt_reg      <= dcnt_next;
         rcnt_reg      <= rcnt_next;
         rep_reg       <= rep_next;
         enable_reg    <= enable_next;
         btn_state_reg <= btn_state_next;
      end
   end

   // Next-state logic: debounce in both directions, repeat timing while held.
   always_comb begin
      state_next     = state_reg;
      dcnt_next      = dcnt_reg;
      rcnt_next      = rcnt_reg;
      rep_next       = rep_reg;
      enable_next    = 1'b0;
      btn_state_next = btn_state_reg;

      case (state_reg)
         IDLE: begin
            if (btn_s) begin
               state_next = DEB_PRESS;
               dcnt_next  = ONE;
            end
         end

         DEB_PRESS: begin
            if (!btn_s) begin
               state_next = IDLE;
               dcnt_next  = '0;
            end else if (dcnt_reg < DEB_MAX) begin
               dcnt_next = dcnt_reg + ONE;
            end else begin
               state_next     = HELD;
               enable_next    = 1'b1;
               btn_state_next = 1'b1;
               dcnt_next      = '0;
               rcnt_next      = '0;
               rep_next       = 1'b0;
            end
         end

         HELD: begin
            // A falling input takes priority over a repeat that would fire now.
            if (!btn_s) begin
               state_next = DEB_RELEASE;
               dcnt_next  = ONE;
            end else if (!repeat_en) begin
               rcnt_next = '0;
               rep_next  = 1'b0;
            end else if (rcnt_inc == rep_limit) begin
               enable_next = 1'b1;
               rcnt_next   = '0;
               rep_next    = 1'b1;
            end else begin
               rcnt_next = rcnt_inc;
            end
         end

         DEB_RELEASE: begin
            // A bounce back to high resumes holding without a new strobe.
            if (btn_s) begin
               state_next = HELD;
               dcnt_next  = '0;
               rcnt_next  = '0;
               rep_next   = 1'b0;
            end else if (dcnt_reg < DEB_MAX) begin
               dcnt_next = dcnt_reg + ONE;
            end else begin
               state_next     = IDLE;
               dcnt_next      = '0;
               btn_state_next = 1'b0;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign enable    = enable_reg;
   assign btn_state = btn_state_reg;

endmodule

// File: tb/tb_enable_pulse_gen.sv
// tb_enable_pulse_gen: directed stimulus with a run-length based behavioural
// model checked every cycle, plus literal pulse-time expectations.
module tb_enable_pulse_gen;

   localparam int DEB = 4;
   localparam int RD  = 16;
   localparam int RR  = 8;
   localparam int CW  = 8;

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic repeat_en;
   logic enable;
   logic btn_state;

   int checks = 0;
   int errors = 0;
   int edge_no = 0;

   // model state
   logic m_s1, m_s2;
   int   m_level, run1, run0, age, bouncing;
   logic exp_en;

   // observation log
   int pulse_q[$];
   int exp_q[$];
   int rise_edge, fall_edge;
   logic prev_bs;

   enable_pulse_gen #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in),
      .repeat_en(repeat_en),
      .enable(enable),
      .btn_state(btn_state)
   );

   always #5 clk = ~clk;

   // Behavioural model: debounced level flips when a run of DEB+1 equal
   // synchronised samples disagrees with it; repeats fire at hold ages
   // RD, RD+RR, RD+2RR, ...
   always @(posedge clk) begin
      logic bs;
      edge_no++;
      if (reset) begin
         m_s1 = 1'b0; m_s2 = 1'b0;
         m_level = 0; run1 = 0; run0 = 0; age = 0; bouncing = 0;
         exp_en = 1'b0;
      end else begin
         bs = m_s2;
         m_s2 = m_s1;
         m_s1 = btn_in;
         exp_en = 1'b0;
         if (bs) begin run1++; run0 = 0; end
         else    begin run0++; run1 = 0; end
         if (m_level == 0) begin
            if (bs && run1 == DEB + 1) begin
               m_level = 1; exp_en = 1'b1; age = 0; bouncing = 0;
            end
         end else begin
            if (!bs) begin
               bouncing = 1;
               if (run0 == DEB + 1) m_level = 0;
            end else if (bouncing != 0) begin
               bouncing = 0; age = 0;
            end else if (!repeat_en) begin
               age = 0;
            end else begin
               age++;
               if (age >= RD && ((age - RD) % RR) == 0) exp_en = 1'b1;
            end
         end
      end
   end

   // Per-cycle compare and event log, away from the active edge.
   always @(negedge clk) begin
      if (edge_no > 0) begin
         checks++;
         if (enable !== exp_en) begin
            errors++;
            $display("FAIL enable edge %0d: got %b want %b", edge_no, enable, exp_en);
         end
         checks++;
         if (btn_state !== m_level[0]) begin
            errors++;
            $display("FAIL btn_state edge %0d: got %b want %0d", edge_no, btn_state, m_level);
         end
         if (enable === 1'b1) pulse_q.push_back(edge_no);
         if (btn_state === 1'b1 && prev_bs !== 1'b1) rise_edge = edge_no;
         if (btn_state === 1'b0 && prev_bs === 1'b1) fall_edge = edge_no;
         prev_bs = btn_state;
      end
   end

   task automatic cyc(input logic b, input logic re, input logic r);
      btn_in = b; repeat_en = re; reset = r;
      @(negedge clk);
      #1;
   endtask

   task automatic cycn(input int n, input logic b, input logic re);
      for (int i = 0; i < n; i++) cyc(b, re, 1'b0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end else begin
         $display("check %s: %0d ok", name, act);
      end
   endtask

   task automatic chk_pulses(input string name);
      checks++;
      if (pulse_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s count: got %0d want %0d", name, pulse_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (pulse_q[i] != exp_q[i]) begin
               errors++;
               $display("FAIL %s pulse %0d: got edge %0d want edge %0d", name, i, pulse_q[i], exp_q[i]);
               break;
            end
         end
         $display("check %s: %0d pulses compared", name, exp_q.size());
      end
      pulse_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int a;
      btn_in = 1'b0; repeat_en = 1'b0; reset = 1'b1;
      rise_edge = -1; fall_edge = -1; prev_bs = 1'b0;

      // reset for edges 1,2 then idle through edge 9
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("reset_enable", int'(enable), 0);
      chk("reset_btn_state", int'(btn_state), 0);
      cycn(7, 1'b0, 1'b0);
      pulse_q.delete();

      // clean press sampled at edge 10, held 12 cycles
      cycn(12, 1'b1, 1'b0);
      exp_q = '{16};
      chk_pulses("clean_press");
      chk("clean_rise_edge", rise_edge, 16);
      cycn(10, 1'b0, 1'b0);
      chk("clean_fall_edge", fall_edge, 28);

      // bouncy press: 1,0,1,0 then stable high
      a = edge_no + 1;
      cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
      cycn(12, 1'b1, 1'b0);
      exp_q = '{a + 10};
      chk_pulses("bouncy_press");
      cycn(10, 1'b0, 1'b0);

      // release bounce while held
      a = edge_no + 1;
      cycn(10, 1'b1, 1'b0);
      cycn(2, 1'b0, 1'b0);
      cycn(10, 1'b1, 1'b0);
      chk("bounce_btn_state_held", int'(btn_state), 1);
      cycn(10, 1'b0, 1'b0);
      exp_q = '{a + 6};
      chk_pulses("release_bounce");
      chk("bounce_fall_edge", fall_edge, a + 28);

      // auto-repeat: held 50 cycles past the press strobe
      a = edge_no + 1;
      cycn(56, 1'b1, 1'b1);
      cycn(10, 1'b0, 1'b1);
      exp_q = '{a + 6, a + 22, a + 30, a + 38, a + 46, a + 54};
      chk_pulses("auto_repeat");

      // reset while debouncing the press (dcnt=3)
      a = edge_no + 1;
      cycn(5, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      chk("rst_deb_enable", int'(enable), 0);
      chk("rst_deb_btn_state", int'(btn_state), 0);
      cycn(10, 1'b1, 1'b0);
      exp_q = '{a + 12};
      chk_pulses("reset_mid_debounce");
      cycn(10, 1'b0, 1'b0);

      // reset in the middle of auto-repeat
      a = edge_no + 1;
      cycn(30, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("rst_rep_btn_state", int'(btn_state), 0);
      cycn(25, 1'b1, 1'b1);
      cycn(10, 1'b0, 1'b0);
      exp_q = '{a + 6, a + 22, a + 37, a + 53};
      chk_pulses("reset_mid_repeat");

      // release lands on the same cycle as the first repeat
      a = edge_no + 1;
      cycn(20, 1'b1, 1'b1);
      cycn(10, 1'b0, 1'b1);
      exp_q = '{a + 6};
      chk_pulses("release_vs_repeat");
      chk("collision_fall_edge", fall_edge, a + 26);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
